// File: rtl/debounce_bank.sv
// debounce_bank: multi-channel tick-sampled button debouncer with edge and auto-repeat pulses
module debounce_bank #(
  parameter int N_CH          = 4,
  parameter int TICK_DIV      = 250000,
  parameter int STABLE_TICKS  = 4,
  parameter int REPEAT_DELAY  = 0,
  parameter int REPEAT_PERIOD = 1
) (
  input  logic            clock_i,
  input  logic            reset_n_i,
  input  logic [N_CH-1:0] signal_i,
  output logic [N_CH-1:0] level_o,
  output logic [N_CH-1:0] rise_pulse_o,
  output logic [N_CH-1:0] fall_pulse_o,
  output logic [N_CH-1:0] press_pulse_o,
  output logic            tick_o
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);
  logic [N_CH-1:0] meta_q, sync_q, level_q, rise_q, fall_q, press_q, flip, fire;
  logic [PW-1:0]   pre_q, pre_d;
  logic            tick;
  assign tick          = pre_q == PRE_LAST;
  assign pre_d         = tick ? '0 : pre_q + 1'b1;
  assign tick_o        = tick;
  assign level_o       = level_q;
  assign rise_pulse_o  = rise_q;
  assign fall_pulse_o  = fall_q;
  assign press_pulse_o = press_q;
  // Synchronize raw pins, run the shared prescaler and register level and pulses
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      meta_q  <= '0;
      sync_q  <= '0;
      pre_q   <= '0;
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      press_q <= '0;
    end else begin
      meta_q  <= signal_i;
      sync_q  <= meta_q;
      pre_q   <= pre_d;
      level_q <= level_q ^ flip;
      rise_q  <= flip & ~level_q;
      fall_q  <= flip & level_q;
      press_q <= (flip & ~level_q) | fire;
    end
  end
  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [CW-1:0] cnt_q, cnt_d;
    logic          differ;
    assign differ  = sync_q[c] != level_q[c];
    assign flip[c] = tick && differ && cnt_q == CNT_LAST;
    assign cnt_d   = !tick ? cnt_q : (!differ || flip[c]) ? '0 : cnt_q + 1'b1;
    // Run length of consecutive samples disagreeing with the accepted level
    always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) cnt_q <= '0;
      else cnt_q <= cnt_d;
    end
    if (REPEAT_DELAY > 0) begin : g_rep
      localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
      localparam int RW = $clog2(RMAX + 1);
      logic [RW-1:0] rep_q, rep_d;
      assign fire[c] = tick && level_q[c] && !flip[c] && rep_q == RW'(1);
      assign rep_d   = flip[c] ? (level_q[c] ? '0 : RW'(REPEAT_DELAY)) :
                       (tick && level_q[c]) ? (fire[c] ? RW'(REPEAT_PERIOD) : rep_q - 1'b1) : rep_q;
      // Ticks remaining until the next auto-repeat while the button is held
      always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) rep_q <= '0;
        else rep_q <= rep_d;
      end
    end else begin : g_norep
      assign fire[c] = 1'b0;
    end
  end
endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank: directed table plus randomized check of debounce_bank against a tick-index model
module tb_debounce_bank;
  localparam int NC = 2, TD = 4, ST = 3, RD = 5, RP = 2;
  logic          clk, rst_n;
  logic [NC-1:0] sig, level, rise, fall, press;
  logic          tick;
  int            checks = 0, failures = 0;
  debounce_bank #(
    .N_CH(NC), .TICK_DIV(TD), .STABLE_TICKS(ST), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clock_i(clk), .reset_n_i(rst_n), .signal_i(sig), .level_o(level),
    .rise_pulse_o(rise), .fall_pulse_o(fall), .press_pulse_o(press), .tick_o(tick)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // Reference model: ticks every TD edges since release, level accepted after ST
  // consecutive differing samples, repeats at fixed tick offsets from the accepted rise.
  logic [NC-1:0] p1, p2, m_lvl, m_rise, m_fall, m_press;
  int            cyc, tickno;
  int            run [NC];
  int            rtick [NC];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1 <= '0; p2 <= '0; cyc <= 0; tickno <= 0;
      m_lvl <= '0; m_rise <= '0; m_fall <= '0; m_press <= '0;
      for (int c = 0; c < NC; c++) begin run[c] <= 0; rtick[c] <= 0; end
    end else begin
      automatic bit tk = ((cyc + 1) % TD) == 0;
      automatic int nt = tickno + (tk ? 1 : 0);
      automatic logic [NC-1:0] nl = m_lvl, r = '0, f = '0, pr = '0;
      for (int c = 0; c < NC; c++) begin
        if (tk) begin
          automatic int nr = (p2[c] != m_lvl[c]) ? run[c] + 1 : 0;
          if (nr == ST) begin
            nr = 0;
            nl[c] = ~m_lvl[c];
            r[c] = ~m_lvl[c];
            f[c] = m_lvl[c];
            if (!m_lvl[c]) rtick[c] <= nt;
          end else if (m_lvl[c] && nt - rtick[c] >= RD && (nt - rtick[c] - RD) % RP == 0) pr[c] = 1'b1;
          run[c] <= nr;
        end
      end
      p1 <= sig; p2 <= p1; cyc <= cyc + 1; tickno <= nt;
      m_lvl <= nl; m_rise <= r; m_fall <= f; m_press <= r | pr;
    end
  end
  task automatic chk(input string n, input logic [NC-1:0] a, input logic [NC-1:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%b exp=%b t=%0t", n, a, e, $time);
    end
  endtask
  task automatic chk_int(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", n, a, e, $time);
    end
  endtask
  task automatic chk_all();
    logic [NC-1:0] et;
    et = {{(NC-1){1'b0}}, (cyc % TD) == TD - 1};
    chk("level", level, m_lvl);
    chk("rise", rise, m_rise);
    chk("fall", fall, m_fall);
    chk("press", press, m_press);
    chk("tick", {{(NC-1){1'b0}}, tick}, et);
  endtask
  typedef struct {
    logic          rst_n;
    logic [NC-1:0] sig;
    int            cycles;
    logic [NC-1:0] lvl;
    int            rises, falls, presses;
  } vec_t;
  vec_t tbl[$];
  function automatic void add(input logic r, input logic [NC-1:0] s, input int n,
                              input logic [NC-1:0] l, input int nr, input int nf, input int np);
    vec_t v;
    v.rst_n = r; v.sig = s; v.cycles = n; v.lvl = l;
    v.rises = nr; v.falls = nf; v.presses = np;
    tbl.push_back(v);
  endfunction
  task automatic run_phase(input vec_t v, input int idx);
    int nr, nf, np;
    nr = 0; nf = 0; np = 0;
    rst_n = v.rst_n;
    sig = v.sig;
    #1 chk_all();
    repeat (v.cycles) begin
      @(posedge clk);
      @(negedge clk);
      chk_all();
      nr += $countones(rise);
      nf += $countones(fall);
      np += $countones(press);
    end
    chk($sformatf("phase%0d_level", idx), level, v.lvl);
    chk_int($sformatf("phase%0d_rises", idx), nr, v.rises);
    chk_int($sformatf("phase%0d_falls", idx), nf, v.falls);
    chk_int($sformatf("phase%0d_presses", idx), np, v.presses);
  endtask
  initial begin
    int n;
    rst_n = 1'b0;
    sig = '0;
    // clean press held 23 ticks: rise at tick 3, repeats at ticks 8,10..22
    add(0, 2'b01, 2, 2'b00, 0, 0, 0);
    add(1, 2'b01, 92, 2'b01, 1, 0, 9);
    // release: one last repeat at tick 24, fall at tick 26, nothing after
    add(1, 2'b00, 20, 2'b00, 0, 1, 1);
    // bounce: two high samples, one low, ten times
    for (int i = 0; i < 10; i++) begin
      add(1, 2'b01, 8, 2'b00, 0, 0, 0);
      add(1, 2'b00, 4, 2'b00, 0, 0, 0);
    end
    // reset with the stability count at 2, then a full 3 ticks to accept
    add(1, 2'b01, 8, 2'b00, 0, 0, 0);
    add(0, 2'b01, 3, 2'b00, 0, 0, 0);
    add(1, 2'b01, 11, 2'b00, 0, 0, 0);
    add(1, 2'b01, 1, 2'b01, 1, 0, 1);
    add(1, 2'b01, 8, 2'b01, 0, 0, 0);
    // independent channels: ch0 sync edge before tick 3, ch1 before tick 5
    add(0, 2'b00, 2, 2'b00, 0, 0, 0);
    add(1, 2'b00, 8, 2'b00, 0, 0, 0);
    add(1, 2'b01, 8, 2'b00, 0, 0, 0);
    add(1, 2'b11, 3, 2'b00, 0, 0, 0);
    add(1, 2'b11, 1, 2'b01, 1, 0, 1);
    add(1, 2'b11, 7, 2'b01, 0, 0, 0);
    add(1, 2'b11, 1, 2'b11, 1, 0, 1);
    add(1, 2'b11, 12, 2'b11, 0, 0, 1);
    repeat (2) @(negedge clk);
    foreach (tbl[i]) run_phase(tbl[i], i);
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        rst_n = 1'b0;
        n = $urandom_range(1, 3);
      end else begin
        rst_n = 1'b1;
        sig = NC'($urandom_range(0, (1 << NC) - 1));
        n = $urandom_range(1, 24);
      end
      #1 chk_all();
      repeat (n) begin
        @(posedge clk);
        @(negedge clk);
        chk_all();
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
